// File: rtl/filter_out_pkg.sv
// Shared constants and the round/saturate helper for the filter output decimator.
package filter_out_pkg;

  localparam int DATA_W     = 18;
  localparam int OUT_W      = 16;
  localparam int DECIM      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int RND_D      = DATA_W - OUT_W;

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [DATA_W:0] RND_HALF = (DATA_W+1)'(32'sd1 <<< (RND_D - 1));
  localparam logic signed [DATA_W:0] SAT_MAX  = (DATA_W+1)'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
  localparam logic signed [DATA_W:0] SAT_MIN  = -(DATA_W+1)'(32'sd1 <<< (OUT_W - 1));

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int dcnt_width(input int decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

  // Round half toward +inf at one extra bit of headroom, then clamp to the output range.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [DATA_W-1:0] din);
    logic signed [DATA_W:0] sum_s;
    logic signed [DATA_W:0] t_s;
    logic [OUT_W-1:0]       res_s;
    sum_s = (DATA_W+1)'(din) + RND_HALF;
    t_s   = sum_s >>> RND_D;
    if (t_s > SAT_MAX) begin
      res_s = SAT_MAX[OUT_W-1:0];
    end else if (t_s < SAT_MIN) begin
      res_s = SAT_MIN[OUT_W-1:0];
    end else begin
      res_s = t_s[OUT_W-1:0];
    end
    return res_s;
  endfunction

endpackage

// File: rtl/filter_out_decimator_fwft_fifo.sv
// First-word-fall-through FIFO: head word is readable combinationally whenever not empty.
module fwft_fifo
  import filter_out_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [lvl_width(DEPTH)-1:0] level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = lvl_width(DEPTH);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] level_nxt_s;
  logic               empty_r;
  logic               full_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign pop_ok_s  = pop && !empty_r;
  assign push_ok_s = push && (!full_r || pop_ok_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + 1'b1;
      2'b01:   level_nxt_s = level_r - 1'b1;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, occupancy and registered empty/full flags.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      level_r <= level_nxt_s;
      empty_r <= (level_nxt_s == '0);
      full_r  <= (level_nxt_s == LEVEL_FULL);
    end
  end

  // Storage array; contents are meaningless after reset because the pointers restart.
  always_ff @(posedge Clk_i) begin
    if (push_ok_s && !Rst_i) mem_r[wr_ptr_r] <= push_data;
  end

  assign head_data = mem_r[rd_ptr_r];
  assign empty     = empty_r;
  assign full      = full_r;
  assign level     = level_r;

endmodule

// File: rtl/filter_out_decimator.sv
// Decimating, rounding output stage behind the systolic filter, with a FWFT buffer and sticky overflow.
module filter_out_decimator
  import filter_out_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int OUT_W      = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                Clk_i,
  input  logic                                Rst_i,
  input  logic signed [DATA_W-1:0]            Data_i,
  input  logic                                DataNd_i,
  output logic [OUT_W-1:0]                    Data_o,
  output logic                                DataValid_o,
  input  logic                                DataReady_i,
  output logic                                Overflow_o,
  output logic [lvl_width(FIFO_DEPTH)-1:0]    Level_o
);

  localparam int LEVEL_W = lvl_width(FIFO_DEPTH);
  localparam int CNT_W   = dcnt_width(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]   dcnt_r;
  logic               stg_v_r;
  logic [OUT_W-1:0]   stg_data_r;
  logic               ovf_r;
  logic [OUT_W-1:0]   head_s;
  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               drop_s;
  logic [LEVEL_W-1:0] level_s;

  // Decimation counter (only advances on valid input) and the round/saturate stage.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      dcnt_r     <= '0;
      stg_v_r    <= 1'b0;
      stg_data_r <= '0;
    end else begin
      stg_v_r <= DataNd_i && (dcnt_r == '0);
      if (DataNd_i) begin
        dcnt_r <= (dcnt_r == CNT_LAST) ? '0 : dcnt_r + 1'b1;
        if (dcnt_r == '0) stg_data_r <= round_sat(Data_i);
      end
    end
  end

  assign pop_s  = !empty_s && DataReady_i;
  assign drop_s = stg_v_r && full_s && !pop_s;

  // Sticky record of any kept word lost to a full buffer.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | drop_s;
    end
  end

  fwft_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk_i     (Clk_i),
    .Rst_i     (Rst_i),
    .push      (stg_v_r),
    .push_data (stg_data_r),
    .pop       (pop_s),
    .head_data (head_s),
    .empty     (empty_s),
    .full      (full_s),
    .level     (level_s)
  );

  // Hide stale memory contents while nothing is offered.
  always_comb begin
    Data_o = '0;
    if (!empty_s) begin
      Data_o = head_s;
    end else begin
      Data_o = '0;
    end
  end

  assign DataValid_o = !empty_s;
  assign Overflow_o  = ovf_r;
  assign Level_o     = level_s;

endmodule
